// File: rtl/button_debouncer.sv
// Debounces a raw asynchronous push-button into a clean synchronous level,
// with one-cycle press/release strobes registered alongside the level.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn,
    output logic debounce,
    output logic press_pulse,
    output logic release_pulse
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             sync1;
    logic             sync2;
    logic [CNT_W-1:0] cnt;

    logic [CNT_W-1:0] cnt_next;
    logic             debounce_next;
    logic             press_next;
    logic             release_next;

    // Any stretch where sync2 agrees with the accepted level restarts the window.
    always_comb begin
        cnt_next      = '0;
        debounce_next = debounce;
        press_next    = 1'b0;
        release_next  = 1'b0;
        if (sync2 != debounce) begin
            if (cnt == CNT_LAST) begin
                debounce_next = sync2;
                press_next    = sync2;
                release_next  = ~sync2;
            end else begin
                cnt_next = cnt + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1         <= 1'b0;
            sync2         <= 1'b0;
            cnt           <= '0;
            debounce      <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            sync1         <= btn;
            sync2         <= sync1;
            cnt           <= cnt_next;
            debounce      <= debounce_next;
            press_pulse   <= press_next;
            release_pulse <= release_next;
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: reset, bounce rejection, press/release
// latency and strobes, glitch rejection, and reset in the middle of a count.
module tb_button_debouncer;

    localparam int D = 1000;

    logic clk = 1'b0;
    logic reset;
    logic btn;
    logic debounce;
    logic press_pulse;
    logic release_pulse;

    int errors = 0;
    int checks = 0;

    int rise_at, fall_at, press_at, release_at;
    int press_cnt, release_cnt, overlap_cnt;

    button_debouncer #(.DEBOUNCE_CYCLES(D)) dut (
        .clk           (clk),
        .reset         (reset),
        .btn           (btn),
        .debounce      (debounce),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #10 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Run n edges, recording the edge index (1-based) of the first level
    // change in each direction and of each strobe, plus strobe counts.
    task automatic watch(input int n);
        logic prev;
        rise_at = -1; fall_at = -1; press_at = -1; release_at = -1;
        press_cnt = 0; release_cnt = 0; overlap_cnt = 0;
        prev = debounce;
        for (int i = 1; i <= n; i++) begin
            step();
            if (debounce === 1'b1 && prev === 1'b0 && rise_at < 0) rise_at = i;
            if (debounce === 1'b0 && prev === 1'b1 && fall_at < 0) fall_at = i;
            if (press_pulse === 1'b1) begin
                press_cnt++;
                if (press_at < 0) press_at = i;
            end
            if (release_pulse === 1'b1) begin
                release_cnt++;
                if (release_at < 0) release_at = i;
            end
            if (press_pulse === 1'b1 && release_pulse === 1'b1) overlap_cnt++;
            prev = debounce;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        btn   = 1'b1;
        repeat (5) step();
        checks++; if (debounce !== 1'b0) begin errors++; $display("FAIL reset_debounce: got %b expected 0", debounce); end
        checks++; if (press_pulse !== 1'b0) begin errors++; $display("FAIL reset_press: got %b expected 0", press_pulse); end
        checks++; if (release_pulse !== 1'b0) begin errors++; $display("FAIL reset_release: got %b expected 0", release_pulse); end
        checks++; if (dut.cnt !== '0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", dut.cnt); end
        btn = 1'b0;
        step();
        reset = 1'b1;
        watch(5);
        checks++; if (debounce !== 1'b0 || press_cnt !== 0) begin errors++; $display("FAIL reset_idle: debounce %b presses %0d expected 0 0", debounce, press_cnt); end
    endtask

    task automatic test_bounce();
        int bad;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            btn = 1'b1;
            step();
            if (debounce !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0) bad++;
            btn = 1'b0;
            step();
            if (debounce !== 1'b0 || press_pulse !== 1'b0 || release_pulse !== 1'b0) bad++;
        end
        watch(20);
        checks++; if (bad !== 0 || rise_at !== -1 || press_cnt !== 0) begin
            errors++; $display("FAIL bounce: bad cycles %0d rise at %0d presses %0d expected 0 -1 0", bad, rise_at, press_cnt);
        end
        checks++; if (debounce !== 1'b0) begin errors++; $display("FAIL bounce_level: got %b expected 0", debounce); end
    endtask

    task automatic test_long_press();
        btn = 1'b1;
        watch(5000);
        checks++; if (rise_at !== D + 2) begin errors++; $display("FAIL press_latency: rise at edge %0d expected %0d", rise_at, D + 2); end
        checks++; if (press_cnt !== 1) begin errors++; $display("FAIL press_count: got %0d expected 1", press_cnt); end
        checks++; if (press_at !== D + 2) begin errors++; $display("FAIL press_timing: got edge %0d expected %0d", press_at, D + 2); end
        checks++; if (release_cnt !== 0 || fall_at !== -1) begin errors++; $display("FAIL press_no_release: releases %0d fall %0d expected 0 -1", release_cnt, fall_at); end
        checks++; if (debounce !== 1'b1) begin errors++; $display("FAIL press_level: got %b expected 1", debounce); end
    endtask

    task automatic test_release();
        btn = 1'b0;
        watch(1500);
        checks++; if (fall_at !== D + 2) begin errors++; $display("FAIL release_latency: fall at edge %0d expected %0d", fall_at, D + 2); end
        checks++; if (release_cnt !== 1 || release_at !== D + 2) begin
            errors++; $display("FAIL release_strobe: count %0d at edge %0d expected 1 at %0d", release_cnt, release_at, D + 2);
        end
        checks++; if (press_cnt !== 0 || overlap_cnt !== 0) begin errors++; $display("FAIL release_no_press: presses %0d overlaps %0d expected 0 0", press_cnt, overlap_cnt); end
        checks++; if (debounce !== 1'b0) begin errors++; $display("FAIL release_level: got %b expected 0", debounce); end
    endtask

    task automatic test_glitch();
        btn = 1'b1;
        watch(1100);
        checks++; if (debounce !== 1'b1) begin errors++; $display("FAIL glitch_setup: got %b expected 1", debounce); end
        btn = 1'b0;
        watch(D - 2);
        checks++; if (fall_at !== -1 || release_cnt !== 0) begin errors++; $display("FAIL glitch_low: fall %0d releases %0d expected -1 0", fall_at, release_cnt); end
        btn = 1'b1;
        watch(10);
        checks++; if (fall_at !== -1 || release_cnt !== 0 || debounce !== 1'b1) begin
            errors++; $display("FAIL glitch_recover: fall %0d releases %0d level %b expected -1 0 1", fall_at, release_cnt, debounce);
        end
        checks++; if (dut.cnt !== '0) begin errors++; $display("FAIL glitch_cnt: got %0d expected 0", dut.cnt); end
        btn = 1'b0;
        watch(1100);
        checks++; if (debounce !== 1'b0 || release_cnt !== 1) begin errors++; $display("FAIL glitch_return: level %b releases %0d expected 0 1", debounce, release_cnt); end
    endtask

    task automatic test_midcount_reset();
        btn = 1'b1;
        watch(500);
        checks++; if (rise_at !== -1 || debounce !== 1'b0) begin errors++; $display("FAIL mid_precount: rise %0d level %b expected -1 0", rise_at, debounce); end
        checks++; if (dut.cnt === '0) begin errors++; $display("FAIL mid_counting: cnt %0d expected nonzero", dut.cnt); end
        reset = 1'b0;
        step();
        checks++; if (debounce !== 1'b0 || dut.cnt !== '0 || press_pulse !== 1'b0) begin
            errors++; $display("FAIL mid_reset: level %b cnt %0d press %b expected 0 0 0", debounce, dut.cnt, press_pulse);
        end
        reset = 1'b1;
        watch(1100);
        checks++; if (rise_at !== D + 2) begin errors++; $display("FAIL mid_full_window: rise at edge %0d expected %0d", rise_at, D + 2); end
        checks++; if (press_cnt !== 1) begin errors++; $display("FAIL mid_press_count: got %0d expected 1", press_cnt); end
    endtask

    initial begin
        reset = 1'b0;
        btn   = 1'b0;
        test_reset();
        test_bounce();
        test_long_press();
        test_release();
        test_glitch();
        test_midcount_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
